// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one 1-bit add cell stepped LSB-first over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | one bit pair per edge through the add cell, cnt = bit index
   // DONE  | result valid for one cycle; start here chains the next operation
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic             bit_d;
   logic             carry_d;
`ifdef SERIAL_ADD_OVF_EN
   logic             carry_prev_q;
   logic             ovf_q;
`endif

   always_comb begin
      bit_d   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
      carry_d = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         carry_prev_q <= 1'b0;
         ovf_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
                  op_a_q  <= a;
                  op_b_q  <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt_q   <= '0;
                  sum_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
`ifdef SERIAL_ADD_OVF_EN
                  ovf_q   <= 1'b0;
`endif
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_q   <= {bit_d, sum_q[WIDTH-1:1]};
               op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
               op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
               carry_q <= carry_d;
               if (cnt_q == LAST) begin
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
                  // carry_q here is the carry into the MSB
                  carry_prev_q <= carry_q;
                  ovf_q        <= carry_q ^ carry_d;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes model results, a monitor pops on done.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;
   logic         ovf_w;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .sum   (sum),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf_w)
`endif
   );

`ifndef SERIAL_ADD_OVF_EN
   assign ovf_w = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endfunction

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic s);
      exp_t e;
      int ux, uy, ix, iy, ir;
      ux = int'(x);
      uy = int'(y);
      ix = x[W-1] ? ux - (1 << W) : ux;
      iy = y[W-1] ? uy - (1 << W) : uy;
      if (s) begin
         ir  = ix - iy;
         e.s = W'(ux - uy);
         e.c = (ux >= uy);
      end else begin
         ir  = ix + iy;
         e.s = W'(ux + uy);
         e.c = ((ux + uy) >= (1 << W));
      end
      e.v = (ir > (1 << (W - 1)) - 1) || (ir < -(1 << (W - 1)));
      return e;
   endfunction

   // Monitor: compare every done pulse against the oldest outstanding expectation.
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("sum", 32'(sum), 32'(e.s));
            check("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", 32'(ovf_w), 32'(e.v));
`endif
            check("busy_with_done", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done_prev), 32'd0);
         end
      end
      done_prev = done;
   end

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input int pulse_at, input int rst_at);
      int k;
      int nbusy;
      bit seen;
      @(negedge clk);
      a = ia; b = ib; sub = isub; start = 1'b1;
      q.push_back(model(ia, ib, isub));
      @(posedge clk); #1;
      start = 1'b0;
      k = 0; nbusy = 0; seen = 1'b0;
      while (!seen && k < 4 * W) begin
         @(negedge clk);
         k++;
         start = (k == pulse_at);
         if (k == pulse_at) begin
            a = W'('hAA); b = ~ib; sub = ~isub;
         end
         if (k == rst_at) begin
            rst = 1'b1;
            q.delete();
            @(posedge clk); #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
            check("rst_ovf", 32'(ovf_w), 32'd0);
            rst = 1'b0;
            return;
         end
         if (done) seen = 1'b1;
         else if (busy) nbusy++;
      end
      start = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      check("busy_cycles", 32'(nbusy), 32'(W));
      check("done_latency", 32'(k), 32'(W + 1));
   endtask

   task automatic back_to_back(input int n);
      logic [W-1:0] xa, xb;
      logic         xs;
      int           gap;
      bit           seen;
      @(negedge clk);
      xa = W'($urandom); xb = W'($urandom); xs = 1'b0;
      a = xa; b = xb; sub = xs; start = 1'b1;
      q.push_back(model(xa, xb, xs));
      for (int i = 0; i < n; i++) begin
         gap = 0; seen = 1'b0;
         while (!seen && gap < 4 * W) begin
            @(negedge clk);
            gap++;
            if (done) seen = 1'b1;
         end
         check("b2b_done_seen", 32'(seen), 32'd1);
         if (i > 0) check("b2b_period", 32'(gap), 32'(W + 1));
         if (i < n - 1) begin
            xa = W'($urandom); xb = ~xa; xs = ~xs;
            a = xa; b = xb; sub = xs;
            q.push_back(model(xa, xb, xs));
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_ovf", 32'(ovf_w), 32'd0);
      rst = 1'b0;

      run_op(8'h5A, 8'h33, 1'b0, 0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 0, 0);
      run_op(8'h10, 8'h20, 1'b1, 0, 0);
      run_op(8'h7F, 8'h01, 1'b0, 0, 0);
      run_op(8'h80, 8'h01, 1'b1, 0, 0);
      run_op(8'h05, 8'h03, 1'b0, 0, 0);
      run_op(8'h00, 8'h00, 1'b1, 0, 0);
      run_op(8'h0F, 8'h01, 1'b0, 3, 0);
      run_op(8'hC3, 8'h5E, 1'b0, 0, 4);
      run_op(8'h01, 8'h02, 1'b0, 0, 0);

      back_to_back(6);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
